uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: DEPTH, default 8, number of byte entries; SHALL be a power of two, at least 2.
REQ-002 Parameter: WIDTH, default 8, data bits per entry.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: flush  input  1  synchronous clear of contents; does not reset overflow.
REQ-006 Port: in_data  input  WIDTH  byte offered by the upstream producer.
REQ-007 Port: in_valid  input  1  producer has a byte on in_data.
REQ-008 Port: in_ready  output  1  FIFO accepts in_data this cycle.
REQ-009 Port: out_data  output  WIDTH  head byte, LSB-first order for the transmitter.
REQ-010 Port: out_parity  output  1  even-parity bit of out_data, when enabled.
REQ-011 Port: out_valid  output  1  head entry present.
REQ-012 Port: out_ready  input  1  transmitter consumes the head byte this cycle.
REQ-013 Port: count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 Port: full / empty  output  1 each  count==DEPTH / count==0.
REQ-015 Port: overflow  output  1  sticky; push attempted while full.

Function
REQ-016 Push SHALL occur when in_valid && in_ready at a rising edge; in_ready SHALL equal !full.
REQ-017 Pop SHALL occur when out_valid && out_ready at a rising edge; out_valid SHALL equal !empty.
REQ-018 out_data SHALL be the entry at the read pointer, read combinationally; it SHALL change only after a pop or a flush.
REQ-019 Write latency: a byte pushed at edge N SHALL appear on out_data with out_valid high from edge N on, when the FIFO was empty.
REQ-020 Ordering: the FIFO SHALL deliver bytes strictly in push order, with no loss or duplication.
REQ-021 Pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full = MSBs differ and low bits equal.
REQ-022 Simultaneous push and pop when neither full nor empty SHALL leave count unchanged and advance both pointers.
REQ-023 When full, a simultaneous pop and push SHALL perform the pop only, because in_ready is low.
REQ-024 When empty, in_valid high SHALL perform the push only, because out_valid is low.
REQ-025 in_valid && full at an edge SHALL set overflow to 1; overflow SHALL hold until reset.
REQ-026 flush SHALL have priority over push and pop in the same cycle: pointers and count go to 0, and no push is stored.
REQ-027 Memory contents SHALL NOT be cleared by reset or flush; outputs SHALL be masked by out_valid only.

Reset
REQ-028 On reset, pointers and count SHALL go to 0: empty=1, full=0, in_ready=1, out_valid=0, overflow=0.
REQ-029 out_data and out_parity SHALL be 0 while empty after reset.
REQ-030 Reset asserted mid-stream SHALL discard all entries on the next edge, and no pop or push SHALL be recorded in that cycle.

Configuration
REQ-031 Macro UART_TX_FIFO_PARITY_EN controls parity generation.
- Defined: each entry stores WIDTH+1 bits, with parity = XOR of in_data computed at push; out_parity presents the stored bit for the head entry.
- Not defined: out_parity SHALL be tied 0, no parity storage SHALL be synthesized, and the port SHALL still exist.

Verification
REQ-032 Reset, then push 0xA5 at edge 1 -> out_valid=1, out_data=0xA5, count=1 after edge 1; out_parity=0 with the macro defined.
REQ-033 Push 8 bytes 0x01..0x08 with out_ready=0 -> full=1, in_ready=0 after the 8th. A 9th in_valid -> overflow=1, and the data remains 0x01..0x08.
REQ-034 Full FIFO, out_ready=1 and in_valid=1 with 0x55 for one cycle -> pop 0x01 only, count=7, 0x55 not stored.
REQ-035 Continuous push and pop for 20 bytes 0x10..0x23 with count=3 -> count stays 3 and the output sequence matches the input, confirming pointer wrap.
REQ-036 With 4 entries, flush=1 and in_valid=1 in the same cycle -> count=0, empty=1, overflow unchanged.
REQ-037 Reset asserted with 5 entries, out_ready=1 -> next cycle count=0, out_valid=0, and no byte is delivered.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between an upstream producer and a UART transmitter; the head entry is read combinationally.
// Optional feature macro: UART_TX_FIFO_PARITY_EN stores an even-parity bit with every entry.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_parity,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

`ifdef UART_TX_FIFO_PARITY_EN
  localparam int EW = WIDTH + 1;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`else
  localparam int EW = WIDTH;
`endif

  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          overflow_r;
  logic [EW-1:0] mem_r [DEPTH];
  logic [EW-1:0] wr_entry_s;
  logic [EW-1:0] head_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign push_s  = in_valid && !full_s;
  assign pop_s   = out_ready && !empty_s;
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

  // Entry written into storage: data, plus its parity bit when enabled.
  always_comb begin
`ifdef UART_TX_FIFO_PARITY_EN
    wr_entry_s = {even_parity(in_data), in_data};
`else
    wr_entry_s = in_data;
`endif
  end

  // Pointer and sticky-overflow state; reset wins over flush, flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (in_valid && full_s) begin
        overflow_r <= 1'b1;
      end
      if (flush) begin
        wr_ptr_r <= {(AW+1){1'b0}};
        rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        end
      end
    end
  end

  // Storage array; contents survive reset and flush, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s && !flush && !reset) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_entry_s;
    end
  end

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = overflow_r;
  assign count     = wr_ptr_r - rd_ptr_r;
  assign out_data  = empty_s ? {WIDTH{1'b0}} : head_s[WIDTH-1:0];

`ifdef UART_TX_FIFO_PARITY_EN
  assign out_parity = empty_s ? 1'b0 : head_s[WIDTH];
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios then random traffic against a queue model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;

  logic [WIDTH-1:0] q[$];
  logic             ovf_m;
  int               errors = 0;
  int               checks = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_parity(out_parity), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the queue model.
  task automatic check_all(input string tag);
    logic [WIDTH-1:0] hd;
    logic             par;
    int               n;
    n  = q.size();
    hd = '0;
    if (n > 0) hd = q[0];
`ifdef UART_TX_FIFO_PARITY_EN
    par = (n > 0) ? ^hd : 1'b0;
`else
    par = 1'b0;
`endif
    chk($sformatf("%s.count", tag),     32'(count),     32'(n));
    chk($sformatf("%s.full", tag),      32'(full),      32'(n == DEPTH));
    chk($sformatf("%s.empty", tag),     32'(empty),     32'(n == 0));
    chk($sformatf("%s.in_ready", tag),  32'(in_ready),  32'(n != DEPTH));
    chk($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(n != 0));
    chk($sformatf("%s.out_data", tag),  32'(out_data),  32'(hd));
    chk($sformatf("%s.parity", tag),    32'(out_parity), 32'(par));
    chk($sformatf("%s.overflow", tag),  32'(overflow),  32'(ovf_m));
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then check.
  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                      input logic r, input logic fl, input logic rst);
    int pre;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    pre = q.size();
    if (rst) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (v && pre == DEPTH) ovf_m = 1'b1;
      if (fl) begin
        q.delete();
      end else begin
        if (r && pre > 0) void'(q.pop_front());
        if (v && pre < DEPTH) q.push_back(d);
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic v, r, fl, rst;
    ovf_m = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;

    step("reset0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("reset1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Single push shows up on the head the same edge.
    step("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5.parity_even", 32'(out_parity), 32'd0);

    // Fill to full, then an extra push sets overflow and is dropped.
    step("rst_fill", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step("overflow", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);

    // Full with push and pop together: only the pop happens.
    step("full_pop_push", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step("drain_full", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Steady-state streaming at occupancy 3 wraps the pointers several times.
    for (int i = 8'h10; i <= 8'h12; i++) step("stream_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 8'h13; i <= 8'h23; i++) step("stream", 1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("stream_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush with a concurrent push clears everything but keeps overflow.
    for (int i = 0; i < 4; i++) step("pre_flush", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step("flush_push", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("flush.overflow_kept", 32'(overflow), 32'd1);

    // Reset mid-stream discards entries and delivers nothing.
    for (int i = 0; i < 5; i++) step("pre_reset", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    step("reset_mid", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step("after_reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random traffic: push-heavy then pop-heavy phases.
    for (int i = 0; i < 600; i++) begin
      if (i < 300) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      fl  = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 80) == 0);
      step("random", v, 8'($urandom_range(0, 255)), r, fl, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
